// File: rtl/cricket_pkg.sv
// Shared types for the match controller: FSM state codes, result codes, over length.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package cricket_pkg;

    localparam int BALLS_PER_OVER = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_ACT = 3'd2,
        S_PLAY     = 3'd3,
        S_FWD      = 3'd4,
        S_CHECK    = 3'd5,
        S_BREAK    = 3'd6,
        S_DONE     = 3'd7
    } match_state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_T1   = 2'b01;
    localparam logic [1:0] RES_T2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    // Balls left in the innings. Saturates at zero so an over-long innings
    // reported by the tracker can never wrap to a large count.
    function automatic logic [7:0] balls_left(input int unsigned max_overs,
                                              input logic [4:0]   overs,
                                              input logic [2:0]   balls);
        logic [8:0] total;
        logic [8:0] bowled;
        total  = 9'(max_overs * BALLS_PER_OVER);
        bowled = 9'(overs) * 9'(BALLS_PER_OVER) + 9'(balls);
        return (bowled >= total) ? 8'd0 : 8'(total - bowled);
    endfunction

endpackage

// File: rtl/cricket_innings_judge.sv
// Decides whether the current innings is over and decodes the match result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, consumed only in CHECK.
//
// Ports:
//   trk_balls/overs/total_runs/wickets  tracker score for the current innings
//   innings_num                          0 = first innings, 1 = second
//   target                               runs needed to win in innings 2
//   innings_over                         any innings-ending condition holds
//   result_code                          result if this were the end of innings 2
module cricket_innings_judge
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS   = 20,
    parameter int MAX_WICKETS = 10
) (
    input  logic [2:0]  trk_balls,
    input  logic [4:0]  trk_overs,
    input  logic [15:0] trk_total_runs,
    input  logic [3:0]  trk_wickets,
    input  logic        innings_num,
    input  logic [15:0] target,
    output logic        innings_over,
    output logic [1:0]  result_code
);

    logic all_out;
    logic overs_done;
    logic chased;

    assign all_out    = trk_wickets >= 4'(MAX_WICKETS);
    assign overs_done = (trk_overs == 5'(MAX_OVERS)) && (trk_balls == 3'd0);
    assign chased     = trk_total_runs >= target;

    // The chase only counts in the second innings; in the first the target is meaningless.
    assign innings_over = all_out || overs_done || (innings_num && chased);

    // Reaching the target wins even if the same ball was the last or the tenth wicket.
    always_comb begin
        result_code = RES_T1;
        if (chased) begin
            result_code = RES_T2;
        end else if (trk_total_runs == target - 16'd1) begin
            result_code = RES_TIE;
        end
    end

endmodule

// File: rtl/cricket_match_controller.sv
// Sequences a two-innings, overs-limited match around one external ball tracker.
// Latency: ball accepted at N, tracker pulse at N+1, evaluated at N+2, next accept at N+3 earliest.
// Backpressure: ball_ready high only in PLAY; ball_valid_in is ignored whenever ball_ready is low.
//
// Ports:
//   clk, reset_n                     clock and asynchronous active-low reset
//   match_start                      start pulse, honoured only in IDLE or DONE
//   ball_valid_in/runs_in/wicket_in  scorer ball handshake, ball_ready back
//   trk_start_innings/ball_bowled/runs_scored/wicket_fallen   commands to tracker
//   trk_balls/overs/total_runs/wickets/innings_active        status from tracker
//   match_state, innings_num, first_innings_runs, target,
//   balls_remaining, result, match_done                      match status
module cricket_match_controller
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS    = 20,
    parameter int MAX_WICKETS  = 10,
    parameter int BREAK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        match_start,
    input  logic        ball_valid_in,
    input  logic [2:0]  runs_in,
    input  logic        wicket_in,
    output logic        ball_ready,
    output logic        trk_start_innings,
    output logic        trk_ball_bowled,
    output logic [2:0]  trk_runs_scored,
    output logic        trk_wicket_fallen,
    input  logic [2:0]  trk_balls,
    input  logic [4:0]  trk_overs,
    input  logic [15:0] trk_total_runs,
    input  logic [3:0]  trk_wickets,
    input  logic        trk_innings_active,
    output logic [2:0]  match_state,
    output logic        innings_num,
    output logic [15:0] first_innings_runs,
    output logic [15:0] target,
    output logic [7:0]  balls_remaining,
    output logic [1:0]  result,
    output logic        match_done
);

    localparam int              BRK_W    = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_CYCLES - 1);

    match_state_t     state;
    match_state_t     state_nxt;
    logic [2:0]       ball_runs_q;
    logic             ball_wkt_q;
    logic [BRK_W-1:0] brk_cnt;
    logic             innings_over;
    logic [1:0]       result_code;
    logic             start_ok;
    logic             accept;
    logic             innings_end;

    cricket_innings_judge #(
        .MAX_OVERS   (MAX_OVERS),
        .MAX_WICKETS (MAX_WICKETS)
    ) u_judge (
        .trk_balls      (trk_balls),
        .trk_overs      (trk_overs),
        .trk_total_runs (trk_total_runs),
        .trk_wickets    (trk_wickets),
        .innings_num    (innings_num),
        .target         (target),
        .innings_over   (innings_over),
        .result_code    (result_code)
    );

    assign start_ok    = ((state == S_IDLE) || (state == S_DONE)) && match_start;
    assign accept      = (state == S_PLAY) && ball_valid_in;
    assign innings_end = (state == S_CHECK) && innings_over;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        ball_ready        = 1'b0;
        trk_start_innings = 1'b0;
        trk_ball_bowled   = 1'b0;
        trk_runs_scored   = 3'd0;
        trk_wicket_fallen = 1'b0;
        match_done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (match_start) state_nxt = S_START;
            end
            S_START: begin
                trk_start_innings = 1'b1;
                state_nxt         = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (trk_innings_active) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                ball_ready = 1'b1;
                if (ball_valid_in) state_nxt = S_FWD;
            end
            S_FWD: begin
                trk_ball_bowled   = 1'b1;
                trk_runs_scored   = ball_runs_q;
                trk_wicket_fallen = ball_wkt_q;
                state_nxt         = S_CHECK;
            end
            S_CHECK: begin
                // Tracker took the ball on the FWD edge, so its outputs are current here.
                if (innings_over) begin
                    state_nxt = innings_num ? S_DONE : S_BREAK;
                end else begin
                    state_nxt = S_PLAY;
                end
            end
            S_BREAK: begin
                if (brk_cnt == BRK_LAST) state_nxt = S_START;
            end
            S_DONE: begin
                match_done = 1'b1;
                if (match_start) state_nxt = S_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            innings_num        <= 1'b0;
            first_innings_runs <= 16'd0;
            target             <= 16'd0;
            result             <= RES_NONE;
            ball_runs_q        <= 3'd0;
            ball_wkt_q         <= 1'b0;
            brk_cnt            <= '0;
        end else begin
            if (start_ok) begin
                innings_num        <= 1'b0;
                first_innings_runs <= 16'd0;
                target             <= 16'd0;
                result             <= RES_NONE;
            end
            if (accept) begin
                ball_runs_q <= runs_in;
                ball_wkt_q  <= wicket_in;
            end
            if (innings_end) begin
                if (!innings_num) begin
                    first_innings_runs <= trk_total_runs;
                    target             <= trk_total_runs + 16'd1;
                end else begin
                    result <= result_code;
                end
            end
            if (state == S_CHECK) begin
                brk_cnt <= '0;
            end else if (state == S_BREAK) begin
                brk_cnt <= brk_cnt + 1'b1;
                if (brk_cnt == BRK_LAST) innings_num <= 1'b1;
            end
        end
    end

    assign match_state     = state;
    assign balls_remaining = balls_left(MAX_OVERS, trk_overs, trk_balls);

endmodule

// File: tb/tb_cricket_match_controller.sv
// Bench for cricket_match_controller with a behavioural ball tracker and scoreboards
// for forwarded balls and innings-end snapshots.
// Backpressure: scorer stimulus waits on ball_ready, and some sequences hold ball_valid_in high.
module tb_cricket_match_controller;
    import cricket_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        match_start;
    logic        ball_valid_in;
    logic [2:0]  runs_in;
    logic        wicket_in;
    logic        ball_ready;
    logic        trk_start_innings;
    logic        trk_ball_bowled;
    logic [2:0]  trk_runs_scored;
    logic        trk_wicket_fallen;
    logic [2:0]  trk_balls;
    logic [4:0]  trk_overs;
    logic [15:0] trk_total_runs;
    logic [3:0]  trk_wickets;
    logic        trk_innings_active;
    logic [2:0]  match_state;
    logic        innings_num;
    logic [15:0] first_innings_runs;
    logic [15:0] target;
    logic [7:0]  balls_remaining;
    logic [1:0]  result;
    logic        match_done;

    cricket_match_controller #(
        .MAX_OVERS    (1),
        .MAX_WICKETS  (2),
        .BREAK_CYCLES (4)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .match_start        (match_start),
        .ball_valid_in      (ball_valid_in),
        .runs_in            (runs_in),
        .wicket_in          (wicket_in),
        .ball_ready         (ball_ready),
        .trk_start_innings  (trk_start_innings),
        .trk_ball_bowled    (trk_ball_bowled),
        .trk_runs_scored    (trk_runs_scored),
        .trk_wicket_fallen  (trk_wicket_fallen),
        .trk_balls          (trk_balls),
        .trk_overs          (trk_overs),
        .trk_total_runs     (trk_total_runs),
        .trk_wickets        (trk_wickets),
        .trk_innings_active (trk_innings_active),
        .match_state        (match_state),
        .innings_num        (innings_num),
        .first_innings_runs (first_innings_runs),
        .target             (target),
        .balls_remaining    (balls_remaining),
        .result             (result),
        .match_done         (match_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tracker: start_innings clears the score and re-raises innings_active a cycle later.
    logic act_pend;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_balls <= 3'd0; trk_overs <= 5'd0; trk_total_runs <= 16'd0;
            trk_wickets <= 4'd0; trk_innings_active <= 1'b0; act_pend <= 1'b0;
        end else begin
            if (act_pend) begin
                trk_innings_active <= 1'b1;
                act_pend           <= 1'b0;
            end
            if (trk_start_innings) begin
                trk_balls <= 3'd0; trk_overs <= 5'd0; trk_total_runs <= 16'd0;
                trk_wickets <= 4'd0; trk_innings_active <= 1'b0; act_pend <= 1'b1;
            end else if (trk_ball_bowled) begin
                trk_total_runs <= trk_total_runs + 16'(trk_runs_scored);
                trk_wickets    <= trk_wickets + 4'(trk_wicket_fallen);
                if (trk_balls == 3'd5) begin
                    trk_balls <= 3'd0;
                    trk_overs <= trk_overs + 5'd1;
                end else begin
                    trk_balls <= trk_balls + 3'd1;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] r;
        logic       w;
        int         c;
    } ball_t;

    typedef struct {
        logic        inn;
        logic [15:0] first;
        logic [15:0] tgt;
        logic [1:0]  res;
        logic [7:0]  brem;
        logic        done;
    } end_t;

    ball_t bq[$];
    end_t  eq[$];
    int    cyc     = 0;
    int    n_acc   = 0;
    int    n_pulse = 0;
    logic [2:0] prev_state = 3'd0;

    always @(posedge clk) cyc++;

    // Monitor, sampled 2ns after the falling edge when inputs and outputs are settled.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && ball_valid_in && ball_ready) begin
            bq.push_back('{r: runs_in, w: wicket_in, c: cyc});
            n_acc++;
        end
        if (trk_ball_bowled) begin
            ball_t b;
            n_pulse++;
            check_eq("pulse_expected", 32'(bq.size() > 0), 32'd1);
            if (bq.size() > 0) begin
                b = bq.pop_front();
                check_eq("fwd_runs", 32'(trk_runs_scored), 32'(b.r));
                check_eq("fwd_wicket", 32'(trk_wicket_fallen), 32'(b.w));
                check_eq("fwd_latency", 32'(cyc - b.c), 32'd1);
            end
        end
        if (match_state != prev_state &&
            (match_state == 3'(S_BREAK) || match_state == 3'(S_DONE))) begin
            end_t e;
            check_eq("end_expected", 32'(eq.size() > 0), 32'd1);
            if (eq.size() > 0) begin
                e = eq.pop_front();
                check_eq("end_innings", 32'(innings_num), 32'(e.inn));
                check_eq("end_first_runs", 32'(first_innings_runs), 32'(e.first));
                check_eq("end_target", 32'(target), 32'(e.tgt));
                check_eq("end_result", 32'(result), 32'(e.res));
                check_eq("end_balls_rem", 32'(balls_remaining), 32'(e.brem));
                check_eq("end_done", 32'(match_done), 32'(e.done));
            end
        end
        prev_state = match_state;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rl[6];
    int wl[6];

    task automatic push_end(input logic inn, input logic [15:0] f, input logic [15:0] t,
                            input logic [1:0] r, input logic [7:0] b, input logic d);
        eq.push_back('{inn: inn, first: f, tgt: t, res: r, brem: b, done: d});
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (match_state !== s && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(match_state), 32'(s));
    endtask

    task automatic send_ball(input logic [2:0] r, input logic w);
        int n = 0;
        while (!ball_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", 32'(ball_ready), 32'd1);
        ball_valid_in = 1'b1;
        runs_in       = r;
        wicket_in     = w;
        @(negedge clk);
        ball_valid_in = 1'b0;
        wicket_in     = 1'b0;
    endtask

    task automatic play_seq(input int n);
        for (int i = 0; i < n; i++) send_ball(3'(rl[i]), wl[i][0]);
    endtask

    task automatic start_match();
        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        check_eq("start_state", 32'(match_state), 32'(S_START));
        check_eq("start_pulse", 32'(trk_start_innings), 32'd1);
    endtask

    task automatic break_phase();
        int n = 0;
        wait_state(3'(S_BREAK), "enter_break");
        while (match_state == 3'(S_BREAK) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("break_len", 32'(n), 32'd4);
        check_eq("break_to_start", 32'(match_state), 32'(S_START));
        check_eq("inn2_start_pulse", 32'(trk_start_innings), 32'd1);
        check_eq("inn2_num", 32'(innings_num), 32'd1);
    endtask

    task automatic inn1_13();
        rl = '{1, 0, 4, 2, 0, 6};
        wl = '{0, 0, 0, 0, 1, 0};
        play_seq(6);
    endtask

    initial begin
        int a0;
        int p0;
        reset_n = 1'b0; match_start = 1'b0; ball_valid_in = 1'b0;
        runs_in = 3'd0; wicket_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(match_state), 32'(S_IDLE));
        check_eq("rst_ready", 32'(ball_ready), 32'd0);
        check_eq("rst_start", 32'(trk_start_innings), 32'd0);
        check_eq("rst_bowled", 32'(trk_ball_bowled), 32'd0);
        check_eq("rst_runs", 32'(trk_runs_scored), 32'd0);
        check_eq("rst_wkt", 32'(trk_wicket_fallen), 32'd0);
        check_eq("rst_innings", 32'(innings_num), 32'd0);
        check_eq("rst_first", 32'(first_innings_runs), 32'd0);
        check_eq("rst_target", 32'(target), 32'd0);
        check_eq("rst_balls_rem", 32'(balls_remaining), 32'd6);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_done", 32'(match_done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Match A: 13 in innings 1, chase completed on ball 4 of innings 2.
        push_end(1'b0, 16'd13, 16'd14, 2'b00, 8'd0, 1'b0);
        push_end(1'b1, 16'd13, 16'd14, 2'b10, 8'd2, 1'b1);
        start_match();
        inn1_13();
        break_phase();
        rl = '{4, 4, 4, 2, 0, 0};
        wl = '{0, 0, 0, 0, 0, 0};
        play_seq(4);
        wait_state(3'(S_DONE), "a_done");
        check_eq("a_done_ready", 32'(ball_ready), 32'd0);
        a0 = n_acc; p0 = n_pulse;
        ball_valid_in = 1'b1; runs_in = 3'd5;
        repeat (12) @(negedge clk);
        ball_valid_in = 1'b0;
        check_eq("a_no_accept_after", 32'(n_acc - a0), 32'd0);
        check_eq("a_no_pulse_after", 32'(n_pulse - p0), 32'd0);
        check_eq("a_still_done", 32'(match_state), 32'(S_DONE));

        // Match B: restart from DONE clears the result; innings 2 ties on 13.
        push_end(1'b0, 16'd13, 16'd14, 2'b00, 8'd0, 1'b0);
        push_end(1'b1, 16'd13, 16'd14, 2'b11, 8'd0, 1'b1);
        start_match();
        check_eq("b_clr_result", 32'(result), 32'd0);
        check_eq("b_clr_target", 32'(target), 32'd0);
        check_eq("b_clr_first", 32'(first_innings_runs), 32'd0);
        check_eq("b_clr_innings", 32'(innings_num), 32'd0);
        wait_state(3'(S_PLAY), "b_play");
        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        check_eq("b_start_ignored", 32'(match_state), 32'(S_PLAY));
        check_eq("b_no_start_pulse", 32'(trk_start_innings), 32'd0);
        inn1_13();
        break_phase();
        rl = '{2, 2, 2, 2, 2, 3};
        wl = '{0, 0, 0, 0, 0, 0};
        play_seq(6);
        wait_state(3'(S_DONE), "b_done");

        // Match C: innings 2 falls one short of a tie.
        push_end(1'b0, 16'd13, 16'd14, 2'b00, 8'd0, 1'b0);
        push_end(1'b1, 16'd13, 16'd14, 2'b01, 8'd0, 1'b1);
        start_match();
        inn1_13();
        break_phase();
        rl = '{2, 2, 2, 2, 2, 2};
        play_seq(6);
        wait_state(3'(S_DONE), "c_done");

        // Match D: all out at 0.2, then a held-valid chase of 1.
        push_end(1'b0, 16'd0, 16'd1, 2'b00, 8'd4, 1'b0);
        push_end(1'b1, 16'd0, 16'd1, 2'b10, 8'd2, 1'b1);
        start_match();
        rl = '{0, 0, 0, 0, 0, 0};
        wl = '{1, 1, 0, 0, 0, 0};
        play_seq(2);
        break_phase();
        wait_state(3'(S_PLAY), "d_play");
        a0 = n_acc;
        ball_valid_in = 1'b1; runs_in = 3'd0; wicket_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_eq("held_ready_pattern", 32'(ball_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i == 8) ball_valid_in = 1'b0;
            @(negedge clk);
        end
        check_eq("held_accepts", 32'(n_acc - a0), 32'd3);
        send_ball(3'd1, 1'b0);
        wait_state(3'(S_DONE), "d_done");

        // Match E: reset while a ball is being forwarded.
        start_match();
        send_ball(3'd3, 1'b0);
        check_eq("e_in_fwd", 32'(match_state), 32'(S_FWD));
        p0 = n_pulse;
        reset_n = 1'b0;
        #1;
        check_eq("e_rst_state", 32'(match_state), 32'(S_IDLE));
        check_eq("e_rst_bowled", 32'(trk_ball_bowled), 32'd0);
        check_eq("e_rst_runs", 32'(trk_runs_scored), 32'd0);
        check_eq("e_rst_ready", 32'(ball_ready), 32'd0);
        check_eq("e_rst_balls_rem", 32'(balls_remaining), 32'd6);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("e_no_pulse", 32'(n_pulse - p0), 32'd0);
        check_eq("e_aborted_ball", 32'(bq.size()), 32'd1);
        bq.delete();
        check_eq("e_idle_after", 32'(match_state), 32'(S_IDLE));
        check_eq("all_ends_seen", 32'(eq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
